// File: rtl/s_mem_pkg.sv
// Shared constants and types for the RC4 S-memory arbiter.
package s_mem_pkg;

  localparam int N_REQ = 3;
  localparam int AW    = 8;
  localparam int DW    = 8;

  // Requester indices; a lower index wins when several ask at once.
  localparam int REQ_INIT    = 0;
  localparam int REQ_SHUFFLE = 1;
  localparam int REQ_DECRYPT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/s_mem_arbiter_fixed_prio_pick.sv
// Fixed-priority picker: lowest set request bit wins.
// Gives a one-hot grant, the binary index of the winner and an any-request flag.
module fixed_prio_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the last to overwrite.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Lock-based arbiter for the single-port 256x8 RC4 S-memory.
// A requester owns the RAM for a whole multi-access sequence; reads are
// returned one cycle later tagged to the requester that issued them.
module s_mem_arbiter #(
  parameter int N_REQ = s_mem_pkg::N_REQ,
  parameter int AW    = s_mem_pkg::AW,
  parameter int DW    = s_mem_pkg::DW
) (
  input  logic                clock,
  input  logic                restart,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    acc,
  input  logic [N_REQ-1:0]    wr,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_address,
  output logic [DW-1:0]       mem_data,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q,
  output logic                err
);

  import s_mem_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_reg, state_next;
  logic [IW-1:0]    owner_reg;
  logic [N_REQ-1:0] owner_oh_reg;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] gnt_int;
  logic             own_req, own_acc, own_wr;
  logic [AW-1:0]    own_addr;
  logic [DW-1:0]    own_wdata;
  logic             drive;
  logic [AW-1:0]    addr_hold_reg;
  logic [DW-1:0]    data_hold_reg;
  logic [N_REQ-1:0] rvalid_reg;
  logic             err_reg;

  fixed_prio_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the current owner's request, strobe and address/data lanes.
  always_comb begin
    own_req   = 1'b0;
    own_acc   = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_reg == IW'(i)) begin
        own_req   = req[i];
        own_acc   = acc[i];
        own_wr    = wr[i];
        own_addr  = addr[i*AW +: AW];
        own_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // State register; the owner is captured only when leaving IDLE.
  always_ff @(posedge clock) begin
    if (restart) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      owner_oh_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_any) begin
        owner_reg    <= pick_idx;
        owner_oh_reg <= pick_oh;
      end
    end
  end

  // Next state: IDLE always lasts at least one cycle between locks.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = OWN;
      OWN:     if (!own_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: grant, RAM pins (held when idle) and broadcast read data.
  always_comb begin
    gnt_int     = (state_reg == OWN) ? owner_oh_reg : '0;
    drive       = (state_reg == OWN) && own_acc && !restart;
    gnt         = restart ? '0 : gnt_int;
    mem_wren    = drive && own_wr;
    mem_address = restart ? '0 : (drive ? own_addr  : addr_hold_reg);
    mem_data    = restart ? '0 : (drive ? own_wdata : data_hold_reg);
    rvalid      = restart ? '0 : rvalid_reg;
    rdata       = mem_q;
    err         = err_reg;
  end

  // Remember the last driven address/data so idle cycles do not glitch the pins.
  always_ff @(posedge clock) begin
    if (restart) begin
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else if (drive) begin
      addr_hold_reg <= own_addr;
      data_hold_reg <= own_wdata;
    end
  end

  // Tag each read with its issuer so data arriving after release still routes.
  always_ff @(posedge clock) begin
    if (restart) rvalid_reg <= '0;
    else         rvalid_reg <= (drive && !own_wr) ? owner_oh_reg : '0;
  end

  // Sticky flag for any strobe from a requester that does not hold the lock.
  always_ff @(posedge clock) begin
    if (restart) err_reg <= 1'b0;
    else         err_reg <= err_reg | (|(acc & ~gnt_int));
  end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed testbench for s_mem_arbiter with a behavioural new-data 256x8 RAM.
module tb_s_mem_arbiter;

  logic        clock = 1'b0;
  logic        restart;
  logic [2:0]  req, acc, wr;
  logic [23:0] addr, wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_address, mem_data, mem_q;
  logic        mem_wren, err;

  logic [7:0]  ram [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  s_mem_arbiter dut (
    .clock       (clock),
    .restart     (restart),
    .req         (req),
    .acc         (acc),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .err         (err)
  );

  // Single-port RAM, write-first on a same-cycle read.
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= mem_wren ? mem_data : ram[mem_address];
  end

  task automatic set_acc(input int idx, input logic w, input logic [7:0] a, input logic [7:0] d);
    acc = '0;
    wr  = '0;
    acc[idx] = 1'b1;
    wr[idx]  = w;
    addr[idx*8 +: 8]  = a;
    wdata[idx*8 +: 8] = d;
  endtask

  task automatic test_reset();
    restart = 1'b1; req = 3'b100; acc = '0; wr = '0; addr = '0; wdata = '0;
    @(negedge clock); @(negedge clock); #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b000 || err !== 1'b0 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL reset_flags: rvalid=%b err=%b wren=%b want 000/0/0", rvalid, err, mem_wren); end
    checks++; if (mem_address !== 8'h00 || mem_data !== 8'h00) begin
      errors++; $display("FAIL reset_pins: addr=%h data=%h want 00/00", mem_address, mem_data); end
    @(negedge clock); restart = 1'b0; #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL latency_idle: got %b want 000", gnt); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL latency_grant: got %b want 100", gnt); end
    checks++; if (err !== 1'b0 || rvalid !== 3'b000 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL post_reset_flags: err=%b rvalid=%b wren=%b want 0/000/0", err, rvalid, mem_wren); end
    @(negedge clock); req = 3'b000; #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL release_hold: got %b want 100", gnt); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL release_drop: got %b want 000", gnt); end
    $display("test_reset done");
  endtask

  task automatic test_priority();
    @(negedge clock); req = 3'b111; #1;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL prio_first: got %b want 001", gnt); end
    @(negedge clock); req = 3'b110; #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL prio_hold0: got %b want 001", gnt); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL prio_turn1: got %b want 000", gnt); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL prio_second: got %b want 010", gnt); end
    @(negedge clock); req = 3'b100; #1;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL prio_turn2: got %b want 000", gnt); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL prio_third: got %b want 100", gnt); end
    @(negedge clock); req = 3'b000;
    @(negedge clock);
    $display("test_priority done");
  endtask

  task automatic test_init_sweep();
    int wren_cnt = 0;
    int bad = 0;
    @(negedge clock); req = 3'b001; acc = '0; wr = '0;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL sweep_grant: got %b want 001", gnt); end
    for (int k = 0; k < 256; k++) begin
      @(negedge clock); set_acc(0, 1'b1, 8'(k), 8'(k)); #1;
      if (mem_wren === 1'b1) wren_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); acc = '0; wr = '0; #1;
      if (mem_wren === 1'b1) wren_cnt++;
    end
    checks++; if (wren_cnt != 256) begin errors++; $display("FAIL sweep_wren_count: got %0d want 256", wren_cnt); end
    for (int k = 0; k <= 256; k++) begin
      @(negedge clock);
      if (k < 256) set_acc(0, 1'b0, 8'(k), 8'h00);
      else begin acc = '0; wr = '0; end
      #1;
      if (k > 0) begin
        checks++;
        if (rvalid !== 3'b001 || rdata !== 8'(k - 1)) begin
          errors++; bad++;
          $display("FAIL sweep_readback[%0d]: rvalid=%b rdata=%h want 001/%h", k - 1, rvalid, rdata, 8'(k - 1));
        end
      end
    end
    @(negedge clock); req = 3'b000;
    @(negedge clock);
    $display("test_init_sweep done: 256 writes, %0d bad readbacks", bad);
  endtask

  task automatic test_swap();
    @(negedge clock); req = 3'b010;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL swap_grant: got %b want 010", gnt); end
    @(negedge clock); set_acc(1, 1'b0, 8'h05, 8'h00);
    @(negedge clock); set_acc(1, 1'b0, 8'h0A, 8'h00); #1;
    checks++; if (rvalid !== 3'b010 || rdata !== 8'h05) begin
      errors++; $display("FAIL swap_read_i: rvalid=%b rdata=%h want 010/05", rvalid, rdata); end
    @(negedge clock); set_acc(1, 1'b1, 8'h05, 8'h0A); #1;
    checks++; if (rvalid !== 3'b010 || rdata !== 8'h0A) begin
      errors++; $display("FAIL swap_read_j: rvalid=%b rdata=%h want 010/0a", rvalid, rdata); end
    checks++; if (mem_wren !== 1'b1 || mem_address !== 8'h05 || mem_data !== 8'h0A) begin
      errors++; $display("FAIL swap_write_pins: wren=%b addr=%h data=%h want 1/05/0a", mem_wren, mem_address, mem_data); end
    @(negedge clock); set_acc(1, 1'b1, 8'h0A, 8'h05); #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL swap_no_rvalid: got %b want 000", rvalid); end
    @(negedge clock); set_acc(1, 1'b0, 8'h0A, 8'h00);
    @(negedge clock); set_acc(1, 1'b0, 8'h05, 8'h00); #1;
    checks++; if (rvalid !== 3'b010 || rdata !== 8'h05) begin
      errors++; $display("FAIL swap_raw_0a: rvalid=%b rdata=%h want 010/05", rvalid, rdata); end
    @(negedge clock); acc = '0; wr = '0; #1;
    checks++; if (rvalid !== 3'b010 || rdata !== 8'h0A) begin
      errors++; $display("FAIL swap_after_05: rvalid=%b rdata=%h want 010/0a", rvalid, rdata); end
    @(negedge clock); req = 3'b000;
    @(negedge clock);
    $display("test_swap done");
  endtask

  task automatic test_release_edge();
    @(negedge clock); req = 3'b100;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rel_grant: got %b want 100", gnt); end
    @(negedge clock); req = 3'b000; set_acc(2, 1'b0, 8'hFF, 8'h00); #1;
    checks++; if (gnt !== 3'b100 || mem_address !== 8'hFF) begin
      errors++; $display("FAIL rel_last_acc: gnt=%b addr=%h want 100/ff", gnt, mem_address); end
    @(negedge clock); acc = '0; wr = '0; #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rel_gnt_drop: got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b100 || rdata !== 8'hFF) begin
      errors++; $display("FAIL rel_late_read: rvalid=%b rdata=%h want 100/ff", rvalid, rdata); end
    checks++; if (mem_wren !== 1'b0 || mem_address !== 8'hFF) begin
      errors++; $display("FAIL rel_pin_hold: wren=%b addr=%h want 0/ff", mem_wren, mem_address); end
    @(negedge clock);
    $display("test_release_edge done");
  endtask

  task automatic test_protocol_error();
    @(negedge clock); req = 3'b001;
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b001 || err !== 1'b0) begin
      errors++; $display("FAIL perr_setup: gnt=%b err=%b want 001/0", gnt, err); end
    @(negedge clock); set_acc(2, 1'b1, 8'h10, 8'h99); #1;
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL perr_no_wren: got %b want 0", mem_wren); end
    @(negedge clock); acc = '0; wr = '0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b want 1", err); end
    checks++; if (ram[8'h10] !== 8'h10) begin errors++; $display("FAIL perr_mem: ram[10]=%h want 10", ram[8'h10]); end
    @(negedge clock); @(negedge clock); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", err); end
    $display("test_protocol_error done");
  endtask

  task automatic test_reset_midop();
    @(negedge clock); set_acc(0, 1'b1, 8'h20, 8'h55); #1;
    checks++; if (mem_wren !== 1'b1) begin errors++; $display("FAIL midop_write: wren=%b want 1", mem_wren); end
    @(negedge clock); set_acc(0, 1'b1, 8'h21, 8'h66); restart = 1'b1; #1;
    checks++; if (mem_wren !== 1'b0 || gnt !== 3'b000) begin
      errors++; $display("FAIL midop_reset_cycle: wren=%b gnt=%b want 0/000", mem_wren, gnt); end
    @(negedge clock); restart = 1'b0; req = 3'b000; acc = '0; wr = '0; #1;
    checks++; if (gnt !== 3'b000 || err !== 1'b0) begin
      errors++; $display("FAIL midop_after: gnt=%b err=%b want 000/0", gnt, err); end
    checks++; if (ram[8'h20] !== 8'h55 || ram[8'h21] !== 8'h21) begin
      errors++; $display("FAIL midop_mem: ram[20]=%h ram[21]=%h want 55/21", ram[8'h20], ram[8'h21]); end
    @(negedge clock); #1;
    checks++; if (gnt !== 3'b000 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL midop_idle: gnt=%b wren=%b want 000/0", gnt, mem_wren); end
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_init_sweep();
    test_swap();
    test_release_edge();
    test_protocol_error();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
